// File: rtl/mult_sequencer.sv
// mult_sequencer
// ---------------------------------------------------------------------------
// Control sequencer for a shift-and-add multiplier datapath. One operation
// is LOAD, then WIDTH rounds of TEST -> [ADD] -> SHIFT, then a one-cycle
// DONE pulse. ADD is entered only when the multiplier LSB (X0) is 1 in TEST.
//
// Ports
//   CLK    in   rising-edge clock
//   reset  in   asynchronous active-low reset
//   start  in   operation request, honoured in IDLE only
//   abort  in   synchronous cancel of an operation in progress
//   X0     in   multiplier LSB, looked at in TEST only
//   WEN    out  datapath register-file write enable
//   SEL    out  datapath input mux (0 = external operands, 1 = ALU result)
//   FS     out  ALU function: 00 pass, 01 add, 10 shift-right, 11 clear
//   LD     out  load external operands
//   busy   out  high in every state except IDLE
//   done   out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module mult_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       X0,
  output logic       WEN,
  output logic       SEL,
  output logic [1:0] FS,
  output logic       LD,
  output logic       busy,
  output logic       done
);

  // Counter must hold 0..WIDTH inclusive.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    TEST  = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t        state_reg;
  state_t        state_next;
  logic [CW-1:0] count_reg;

  // Output word {WEN, SEL, FS[1:0], LD, busy, done} for a given state.
  // Outputs are registered from the next state, so the output flops always
  // equal this decode of the current state register.
  function automatic logic [6:0] decode(input state_t s);
    case (s)
      LOAD:    decode = 7'b1_0_11_1_1_0;
      TEST:    decode = 7'b0_0_00_0_1_0;
      ADD:     decode = 7'b1_1_01_0_1_0;
      SHIFT:   decode = 7'b1_1_10_0_1_0;
      DONE:    decode = 7'b0_0_00_0_1_1;
      default: decode = 7'b0_0_00_0_0_0;
    endcase
  endfunction

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start && !abort) state_next = LOAD;
      LOAD:    state_next = abort ? IDLE : TEST;
      TEST:    state_next = abort ? IDLE : (X0 ? ADD : SHIFT);
      ADD:     state_next = abort ? IDLE : SHIFT;
      SHIFT:   state_next = abort ? IDLE :
                            ((count_reg == LAST_ITER) ? DONE : TEST);
      // abort is deliberately ignored here so the completion pulse is kept
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
      {WEN, SEL, FS, LD, busy, done} <= 7'b0;
    end else begin
      state_reg <= state_next;
      {WEN, SEL, FS, LD, busy, done} <= decode(state_next);
      // SHIFT is only reached with count_reg <= WIDTH-1, so the increment
      // tops out at WIDTH.
      if (state_reg == LOAD) begin
        count_reg <= '0;
      end else if (state_reg == SHIFT) begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer
// ---------------------------------------------------------------------------
// Directed + randomised bench for mult_sequencer at WIDTH=8 and WIDTH=1.
// For every operation the reference builds the expected per-cycle output
// trace straight from the operation description (LOAD, then per multiplier
// bit TEST, ADD if the bit is 1, SHIFT, then DONE) and the expected latency
// from 2 + 2*WIDTH + number_of_ones.
// ---------------------------------------------------------------------------
module tb_mult_sequencer;

  logic       clk;
  logic       rst_n;

  logic       start8, abort8, x08;
  logic       wen8, sel8, ld8, busy8, done8;
  logic [1:0] fs8;

  logic       start1, abort1, x01;
  logic       wen1, sel1, ld1, busy1, done1;
  logic [1:0] fs1;

  mult_sequencer #(.WIDTH(8)) u8 (
    .CLK(clk), .reset(rst_n), .start(start8), .abort(abort8), .X0(x08),
    .WEN(wen8), .SEL(sel8), .FS(fs8), .LD(ld8), .busy(busy8), .done(done8)
  );

  mult_sequencer #(.WIDTH(1)) u1 (
    .CLK(clk), .reset(rst_n), .start(start1), .abort(abort1), .X0(x01),
    .WEN(wen1), .SEL(sel1), .FS(fs1), .LD(ld1), .busy(busy1), .done(done1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected output words {WEN, SEL, FS, LD, busy, done}.
  localparam logic [6:0] V_IDLE  = 7'b0_0_00_0_0_0;
  localparam logic [6:0] V_LOAD  = 7'b1_0_11_1_1_0;
  localparam logic [6:0] V_TEST  = 7'b0_0_00_0_1_0;
  localparam logic [6:0] V_ADD   = 7'b1_1_01_0_1_0;
  localparam logic [6:0] V_SHIFT = 7'b1_1_10_0_1_0;
  localparam logic [6:0] V_DONE  = 7'b0_0_00_0_1_1;
  localparam logic [6:0] M_ALL   = 7'b1111111;
  localparam logic [6:0] M_TEST  = 7'b1011111;  // SEL is a don't-care in TEST

  typedef struct {
    logic [6:0] v;
    logic [6:0] m;
    bit         is_test;
    bit         xb;
  } step_t;

  step_t exp_q[$];
  bit    op_bits[$];
  int    errors = 0;
  int    checks = 0;

  function automatic logic [6:0] obs(input bit d1);
    if (d1) obs = {wen1, sel1, fs1, ld1, busy1, done1};
    else    obs = {wen8, sel8, fs8, ld8, busy8, done8};
  endfunction

  task automatic check_vec(input string tag, input logic [6:0] o,
                           input logic [6:0] e, input logic [6:0] m);
    checks++;
    assert ((o & m) === (e & m)) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic check_int(input string tag, input int o, input int e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic drive(input bit d1, input logic s, input logic a, input logic x);
    if (d1) begin start1 = s; abort1 = a; x01 = x; end
    else    begin start8 = s; abort8 = a; x08 = x; end
  endtask

  task automatic push(input logic [6:0] v, input logic [6:0] m, input bit t, input bit xb);
    step_t s;
    s.v = v; s.m = m; s.is_test = t; s.xb = xb;
    exp_q.push_back(s);
  endtask

  task automatic rand_bits(input int w);
    op_bits.delete();
    for (int i = 0; i < w; i++) op_bits.push_back(bit'($urandom_range(0, 1)));
  endtask

  // Runs one operation from IDLE using op_bits as the multiplier bits.
  //   abort_cyc : cycle (1 = LOAD) during which abort is held; -1 = at DONE; 0 = none
  //   start_cyc : cycle during which a stray start is pulsed; 0 = none
  //   reset_cyc : cycle after which reset is pulsed mid-cycle; 0 = none
  task automatic run_op(input string tag, input bit d1, input int abort_cyc,
                        input int start_cyc, input int reset_cyc);
    int ones = 0;
    int done_cyc = 0;
    int a_cyc = abort_cyc;
    int exp_done;
    bit aborted = 0;
    exp_q.delete();
    push(V_LOAD, M_ALL, 0, 0);
    foreach (op_bits[i]) begin
      push(V_TEST, M_TEST, 1, op_bits[i]);
      if (op_bits[i]) begin
        push(V_ADD, M_ALL, 0, 0);
        ones++;
      end
      push(V_SHIFT, M_ALL, 0, 0);
    end
    push(V_DONE, M_ALL, 0, 0);
    exp_done = 2 + 2 * op_bits.size() + ones;
    if (a_cyc < 0) a_cyc = exp_q.size();
    if (a_cyc > 0 && a_cyc < exp_q.size()) begin
      aborted = 1;
      while (exp_q.size() > a_cyc) void'(exp_q.pop_back());
    end
    for (int i = 0; i < 3; i++) push(V_IDLE, M_ALL, 0, 0);

    drive(d1, 1'b1, 1'b0, logic'($urandom_range(0, 1)));
    @(posedge clk); #1;
    for (int k = 1; k <= exp_q.size(); k++) begin
      logic [6:0] o = obs(d1);
      check_vec($sformatf("%s_cyc%0d", tag, k), o, exp_q[k-1].v, exp_q[k-1].m);
      if (o[0] === 1'b1 && done_cyc == 0) done_cyc = k;
      if (k == reset_cyc) begin
        #2 rst_n = 1'b0;
        #1 check_vec($sformatf("%s_async_rst", tag), obs(d1), V_IDLE, M_ALL);
        drive(d1, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_vec($sformatf("%s_rst_hold", tag), obs(d1), V_IDLE, M_ALL);
        #2 rst_n = 1'b1;
        $display("op %s width=%0d reset after cycle %0d", tag, op_bits.size(), k);
        return;
      end
      drive(d1, logic'(k == start_cyc), logic'(k == a_cyc),
            exp_q[k-1].is_test ? logic'(exp_q[k-1].xb) : logic'($urandom_range(0, 1)));
      @(posedge clk); #1;
    end
    drive(d1, 1'b0, 1'b0, 1'b0);
    check_int($sformatf("%s_done_cycle", tag), done_cyc, aborted ? 0 : exp_done);
    $display("op %s width=%0d ones=%0d abort=%0d done_cycle=%0d",
             tag, op_bits.size(), ones, aborted, done_cyc);
  endtask

  initial begin
    rst_n = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset before any clock edge, then held across an edge.
    #3 rst_n = 1'b0;
    #1 check_vec("reset_async_w8", obs(0), V_IDLE, M_ALL);
    check_vec("reset_async_w1", obs(1), V_IDLE, M_ALL);
    @(posedge clk); #1;
    check_vec("reset_hold_w8", obs(0), V_IDLE, M_ALL);
    #2 rst_n = 1'b1;

    // Start on the first edge after release; X0 held 0.
    op_bits.delete();
    for (int i = 0; i < 8; i++) op_bits.push_back(1'b0);
    run_op("x0_zero", 0, 0, 0, 0);

    // X0 held 1: eight ADD cycles.
    op_bits.delete();
    for (int i = 0; i < 8; i++) op_bits.push_back(1'b1);
    run_op("x0_one", 0, 0, 0, 0);

    // Alternating 1,0 with a stray start at cycle 10.
    op_bits.delete();
    for (int i = 0; i < 8; i++) op_bits.push_back(bit'((i % 2) == 0));
    run_op("alt_stray_start", 0, 0, 10, 0);

    // Abort at cycle 7.
    rand_bits(8);
    run_op("abort_c7", 0, 7, 0, 0);

    // start and abort together in IDLE.
    drive(0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_vec($sformatf("start_abort_idle%0d", k), obs(0), V_IDLE, M_ALL);
    end
    drive(0, 1'b0, 1'b0, 1'b0);
    $display("op start_abort_idle width=8 stayed idle");

    // Abort during DONE is ignored.
    rand_bits(8);
    run_op("abort_in_done", 0, -1, 0, 0);

    // Reset pulsed mid-cycle during ADD, then a normal X0=0 run.
    op_bits.delete();
    for (int i = 0; i < 8; i++) op_bits.push_back(1'b1);
    run_op("reset_in_add", 0, 0, 0, 3);
    op_bits.delete();
    for (int i = 0; i < 8; i++) op_bits.push_back(1'b0);
    run_op("after_reset", 0, 0, 0, 0);

    // Random operations.
    for (int n = 0; n < 6; n++) begin
      rand_bits(8);
      run_op($sformatf("rand%0d", n), 0, 0, 0, 0);
    end

    // WIDTH=1.
    op_bits.delete();
    op_bits.push_back(1'b1);
    run_op("w1_x0_one", 1, 0, 0, 0);
    op_bits.delete();
    op_bits.push_back(1'b0);
    run_op("w1_x0_zero", 1, 0, 0, 0);
    op_bits.delete();
    op_bits.push_back(1'b1);
    run_op("w1_abort_c2", 1, 2, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
